// File: rtl/relay_transmit_if.sv
// Host-side word handshake for the relay transmitter.
// The host drives tx_data/tx_valid, and the transmitter answers with tx_ready.
interface relay_transmit_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/relay_transmit.sv
// Relay line transmitter: buffers host words in a small FIFO and sends each one
// as START, MSB-first data and GUARD symbols, each SYMBOL_LEN clocks long, on a fixed symbol grid.
module relay_transmit #(
  parameter int unsigned SYMBOL_LEN = 32,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  relay_transmit_if.slave               tx,
  input  logic                          resync,
  output logic                          data_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned CW = $clog2(SYMBOL_LEN);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] SYM_LAST = CW'(SYMBOL_LEN - 1);
  localparam logic [BW-1:0] BIT_MSB  = BW'(DATA_WIDTH - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE_UNSYNC,
    IDLE_SYNC,
    START,
    DATA,
    GUARD
  } state_t;

  state_t                state, state_next;
  logic [CW-1:0]         sym_cnt;
  logic [BW-1:0]         bit_idx, bit_idx_next;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         rd_ptr, wr_ptr;
  logic                  boundary, fifo_nonempty, push, pop, resync_pend, line_next;

  assign boundary      = (sym_cnt == SYM_LAST);
  assign fifo_nonempty = (fifo_count != '0);
  assign tx.tx_ready   = (fifo_count != FULL_CNT);
  assign push          = tx.tx_valid & tx.tx_ready;
  assign busy          = ((state != IDLE_UNSYNC) && (state != IDLE_SYNC)) || fifo_nonempty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE_UNSYNC;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE_UNSYNC: if (fifo_nonempty) state_next = START;
      IDLE_SYNC: begin
        if (resync_pend)                     state_next = IDLE_UNSYNC;
        else if (boundary && fifo_nonempty)  state_next = START;
      end
      START: if (boundary) state_next = DATA;
      DATA:  if (boundary && (bit_idx == '0)) state_next = GUARD;
      GUARD: begin
        if (boundary) begin
          if (resync_pend)        state_next = IDLE_UNSYNC;
          else if (fifo_nonempty) state_next = START;
          else                    state_next = IDLE_SYNC;
        end
      end
      default: state_next = IDLE_UNSYNC;
    endcase
  end

  // The line is registered, so it is computed from the state being entered.
  always_comb begin
    pop          = (state_next == START) && (state != START);
    bit_idx_next = bit_idx;
    line_next    = 1'b0;
    if (state != DATA)  bit_idx_next = BIT_MSB;
    else if (boundary)  bit_idx_next = bit_idx - 1'b1;
    case (state_next)
      START:   line_next = 1'b1;
      DATA:    line_next = shreg[bit_idx_next];
      default: line_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sym_cnt     <= '0;
      bit_idx     <= BIT_MSB;
      shreg       <= '0;
      data_out    <= 1'b0;
      resync_pend <= 1'b0;
    end else begin
      if ((state == IDLE_UNSYNC) || (state_next == IDLE_UNSYNC) || boundary) sym_cnt <= '0;
      else                                                                sym_cnt <= sym_cnt + 1'b1;
      bit_idx  <= bit_idx_next;
      data_out <= line_next;
      if (pop) shreg <= mem[rd_ptr];
      // Entering IDLE_UNSYNC consumes the request even if resync is high on that same edge.
      if ((state_next == IDLE_UNSYNC) && (state != IDLE_UNSYNC)) resync_pend <= 1'b0;
      else if (resync && (state != IDLE_UNSYNC))                 resync_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx.tx_data;
  end

endmodule

// File: tb/tb_relay_transmit.sv
// Bench for relay_transmit: directed scenarios plus random traffic, with every cycle
// compared against a frame-level timing model of the line, busy, fifo_count and tx_ready.
module tb_relay_transmit;

  localparam int unsigned SL    = 32;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int          FL    = (DW + 2) * SL;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          resync = 1'b0;
  logic          data_out, busy;
  logic [2:0]    fifo_count;

  int unsigned total = 0;
  int unsigned bad   = 0;

  relay_transmit_if #(.DATA_WIDTH(DW)) bus ();

  relay_transmit #(
    .SYMBOL_LEN(SL),
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tx        (bus),
    .resync    (resync),
    .data_out  (data_out),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Frame-level model: a word queue, a grid origin once aligned, and the start time of the frame on the line.
  logic [DW-1:0] qm[$];
  logic [DW-1:0] fword;
  bit            aligned, pend, in_frame;
  int            origin, fs, t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at time %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    qm.delete();
    aligned  = 0;
    pend     = 0;
    in_frame = 0;
    origin   = 0;
    fs       = 0;
    t        = 0;
    fword    = '0;
  endtask

  function automatic bit frame_on();
    return in_frame && (t < fs + FL);
  endfunction

  function automatic logic exp_line();
    int k;
    if (!frame_on()) return 1'b0;
    k = (t - fs) / SL;
    if (k == 0)  return 1'b1;
    if (k <= DW) return fword[DW - k];
    return 1'b0;
  endfunction

  task automatic model_edge(input logic v, input logic [DW-1:0] d, input logic r);
    bit push, nonempty, was_aligned, unsync_now;
    t++;
    push        = v && (qm.size() < DEPTH);
    nonempty    = (qm.size() != 0);
    was_aligned = aligned;
    unsync_now  = 0;
    if (in_frame && (t >= fs + FL)) in_frame = 0;
    if (!in_frame) begin
      if (aligned && pend) begin
        aligned    = 0;
        unsync_now = 1;
      end else if (nonempty && (!aligned || ((t - origin) % SL) == 0)) begin
        fword    = qm.pop_front();
        fs       = t;
        in_frame = 1;
        if (!aligned) begin
          aligned = 1;
          origin  = t;
        end
      end
    end
    if (unsync_now)              pend = 0;
    else if (was_aligned && r)   pend = 1;
    if (push) qm.push_back(d);
  endtask

  task automatic check_all();
    check("data_out",   {31'd0, data_out},       {31'd0, exp_line()});
    check("busy",       {31'd0, busy},           {31'd0, frame_on() || (qm.size() != 0)});
    check("fifo_count", {29'd0, fifo_count},     qm.size());
    check("tx_ready",   {31'd0, bus.tx_ready},   {31'd0, qm.size() < DEPTH});
  endtask

  // Called at a falling edge: check current outputs, then apply inputs for the next rising edge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
    check_all();
    bus.tx_valid = v;
    bus.tx_data  = d;
    resync       = r;
    model_edge(v, d, r);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
  endtask

  logic [DW-1:0] burst [5];
  logic [DW-1:0] loop_words [3];

  initial begin
    burst      = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    loop_words = '{8'h00, 8'hFF, 8'h3C};
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    reset = 1'b1;

    // Single word from unaligned idle, then the line drains to idle-aligned.
    step(1'b1, 8'hA5, 1'b0);
    idle(400);

    // Burst with valid held until five words are accepted.
    for (int i = 0, n = 0; i < 5 && n < 3000; n++) begin
      bit acc;
      acc = (qm.size() < DEPTH);
      step(1'b1, burst[i], 1'b0);
      if (acc) i++;
    end
    idle(1700);

    // Push while idle-aligned: start waits for the next grid boundary.
    idle(10);
    step(1'b1, 8'h01, 1'b0);
    idle(340);

    // Resync mid-frame with a second word queued.
    step(1'b1, 8'h5A, 1'b0);
    step(1'b1, 8'hC3, 1'b0);
    idle(100);
    step(1'b0, '0, 1'b1);
    idle(700);

    // Reset during the data bits with two words queued.
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    idle(100);
    #2 reset = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    check_all();
    reset = 1'b1;
    idle(400);

    // Patterns for the receive path.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, loop_words[i], 1'b0);
      idle(5);
    end
    idle(1000);

    // Random traffic: sparse phase, then a heavy phase with occasional resync.
    for (int i = 0; i < 6000; i++)
      step($urandom_range(0, 99) < 8, DW'($urandom), $urandom_range(0, 999) < 4);
    for (int i = 0; i < 6000; i++)
      step($urandom_range(0, 99) < 70, DW'($urandom), $urandom_range(0, 999) < 2);
    idle(1400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
